// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit handshaked ALU with registered result and flags.
// Build option ALU_SEQ_MUL_EN adds an iterative shift-add MUL (opcode 111).
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             is_zero,
  output logic             is_less_than,
  output logic             illegal_op,
  output logic             busy
);

  localparam int MW = WIDTH - 1;

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;
`endif

  state_t state_r, state_s;
  logic   ready_en_r;
  logic   accept_s;

  logic [WIDTH-1:0] result_r;
  logic             carry_r, ovf_r, zero_r, lt_r, ill_r;

  logic             sub_s, cin_s;
  logic [WIDTH-1:0] b_eff_s, sum_s, sll_s, sra_s;
  logic [MW:0]      low_s;
  logic [1:0]       top_s;
  logic             add_c_s, add_v_s, add_lt_s;
  logic [SHAMT_W-1:0] shamt_s;

  logic [WIDTH-1:0] op_res_s;
  logic             op_c_s, op_v_s, op_lt_s, op_ill_s, op_z_s;

`ifdef ALU_SEQ_MUL_EN
  logic             is_mul_s;
  logic [WIDTH-1:0] acc_r, mcand_r, mplier_r, acc_next_s;
  logic [CNT_W-1:0] count_r;

  assign is_mul_s   = (opcode == 3'b111);
  assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
`endif

  // in_ready stays low until the first edge after reset release
  assign in_ready  = ready_en_r && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  assign result       = result_r;
  assign carry_out    = carry_r;
  assign overflow     = ovf_r;
  assign is_zero      = zero_r;
  assign is_less_than = lt_r;
  assign illegal_op   = ill_r;

  // Bit-slice style adder split at the MSB to expose carry-in and carry-out of the top slice
  always_comb begin
    sub_s    = (opcode == 3'b011) || (opcode == 3'b100);
    cin_s    = sub_s;
    b_eff_s  = sub_s ? ~operand_b : operand_b;
    low_s    = {1'b0, operand_a[MW-1:0]} + {1'b0, b_eff_s[MW-1:0]} + {{MW{1'b0}}, cin_s};
    top_s    = {1'b0, operand_a[MW]} + {1'b0, b_eff_s[MW]} + {1'b0, low_s[MW]};
    sum_s    = {top_s[0], low_s[MW-1:0]};
    add_c_s  = top_s[1];
    add_v_s  = low_s[MW] ^ top_s[1];
    add_lt_s = top_s[0] ^ add_v_s;
    shamt_s  = operand_b[SHAMT_W-1:0];
    sll_s    = operand_a << shamt_s;
    sra_s    = $signed(operand_a) >>> shamt_s;
  end

  // Single-cycle result and flag selection
  always_comb begin
    op_res_s = {WIDTH{1'b0}};
    op_c_s   = 1'b0;
    op_v_s   = 1'b0;
    op_lt_s  = 1'b0;
    op_ill_s = 1'b0;
    case (opcode)
      3'b000: op_res_s = operand_a & operand_b;
      3'b001: op_res_s = operand_a | operand_b;
      3'b010: begin
        op_res_s = sum_s;
        op_c_s   = add_c_s;
        op_v_s   = add_v_s;
      end
      3'b011: begin
        op_res_s = sum_s;
        op_c_s   = add_c_s;
        op_v_s   = add_v_s;
        op_lt_s  = add_lt_s;
      end
      3'b100: begin
        op_res_s = {{MW{1'b0}}, add_lt_s};
        op_lt_s  = add_lt_s;
      end
      3'b101: op_res_s = sll_s;
      3'b110: op_res_s = sra_s;
`ifdef ALU_SEQ_MUL_EN
      3'b111: op_res_s = {WIDTH{1'b0}};
`else
      3'b111: op_ill_s = 1'b1;
`endif
      default: op_res_s = {WIDTH{1'b0}};
    endcase
    op_z_s = (op_res_s == {WIDTH{1'b0}}) && !op_ill_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
`ifdef ALU_SEQ_MUL_EN
          if (is_mul_s) begin
            state_s = EXEC;
          end else begin
            state_s = DONE;
          end
`else
          state_s = DONE;
`endif
        end else if ((state_r == DONE) && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      EXEC: begin
        if (count_r == CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = EXEC;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // State register and post-reset ready enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      ready_en_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      ready_en_r <= 1'b1;
    end
  end

  // Result and flag registers; they only change when a new result is produced
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      lt_r     <= 1'b0;
      ill_r    <= 1'b0;
    end else if (accept_s) begin
      result_r <= op_res_s;
      carry_r  <= op_c_s;
      ovf_r    <= op_v_s;
      zero_r   <= op_z_s;
      lt_r     <= op_lt_s;
      ill_r    <= op_ill_s;
    end
`ifdef ALU_SEQ_MUL_EN
    else if ((state_r == EXEC) && (count_r == CNT_ONE)) begin
      result_r <= acc_next_s;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= (acc_next_s == {WIDTH{1'b0}});
      lt_r     <= 1'b0;
      ill_r    <= 1'b0;
    end
`endif
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiplier: one multiplier bit consumed per EXEC cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (accept_s && is_mul_s) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= operand_a;
      mplier_r <= operand_b;
      count_r  <= CNT_INIT;
    end else if (state_r == EXEC) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r - CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out, overflow, is_zero, is_less_than, illegal_op, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {out_valid, carry_out, overflow, is_zero, is_less_than, illegal_op, result}
  logic [37:0] obs;
  assign obs = {out_valid, carry_out, overflow, is_zero, is_less_than, illegal_op, result};

  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .is_zero(is_zero),
    .is_less_than(is_less_than), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    @(negedge clock);
    in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({obs, busy, in_ready} !== 40'd0) begin
      $display("FAIL reset_state: got %h expected %h", {obs, busy, in_ready}, 40'd0);
      n_fail++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      n_fail++;
    end
  endtask

  task automatic test_add;
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL add_pre_valid: got %b expected 0", out_valid);
      n_fail++;
    end
    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    n_checks++;
    if (obs !== {6'b101000, 32'h8000_0000}) begin
      $display("FAIL add_overflow: got %h expected %h", obs, {6'b101000, 32'h8000_0000});
      n_fail++;
    end
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL add_valid_one_cycle: got %b expected 0", out_valid);
      n_fail++;
    end
    send(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    n_checks++;
    if (obs !== {6'b110100, 32'h0000_0000}) begin
      $display("FAIL add_carry_zero: got %h expected %h", obs, {6'b110100, 32'h0000_0000});
      n_fail++;
    end
  endtask

  task automatic test_logic;
    send(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_checks++;
    if (obs !== {6'b100000, 32'hF000_F000}) begin
      $display("FAIL and_op: got %h expected %h", obs, {6'b100000, 32'hF000_F000});
      n_fail++;
    end
    send(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_checks++;
    if (obs !== {6'b100000, 32'hFFF0_FFF0}) begin
      $display("FAIL or_op: got %h expected %h", obs, {6'b100000, 32'hFFF0_FFF0});
      n_fail++;
    end
  endtask

  task automatic test_sub_slt;
    send(3'b011, 32'd5, 32'd7);
    n_checks++;
    if (obs !== {6'b100010, 32'hFFFF_FFFE}) begin
      $display("FAIL sub_5_7: got %h expected %h", obs, {6'b100010, 32'hFFFF_FFFE});
      n_fail++;
    end
    send(3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
    n_checks++;
    if (obs !== {6'b100010, 32'h0000_0001}) begin
      $display("FAIL slt_neg: got %h expected %h", obs, {6'b100010, 32'h0000_0001});
      n_fail++;
    end
    send(3'b100, 32'h0000_0001, 32'hFFFF_FFFF);
    n_checks++;
    if (obs !== {6'b100100, 32'h0000_0000}) begin
      $display("FAIL slt_pos: got %h expected %h", obs, {6'b100100, 32'h0000_0000});
      n_fail++;
    end
  endtask

  task automatic test_shift_zero;
    send(3'b110, 32'h8000_0000, 32'h0000_0024);
    n_checks++;
    if (obs !== {6'b100000, 32'hF800_0000}) begin
      $display("FAIL sra: got %h expected %h", obs, {6'b100000, 32'hF800_0000});
      n_fail++;
    end
    send(3'b101, 32'h0000_0001, 32'd31);
    n_checks++;
    if (obs !== {6'b100000, 32'h8000_0000}) begin
      $display("FAIL sll: got %h expected %h", obs, {6'b100000, 32'h8000_0000});
      n_fail++;
    end
    send(3'b011, 32'd9, 32'd9);
    n_checks++;
    if (obs !== {6'b110100, 32'h0000_0000}) begin
      $display("FAIL sub_zero: got %h expected %h", obs, {6'b110100, 32'h0000_0000});
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_v;
    @(negedge clock);
    out_ready = 1'b0;
    send(3'b010, 32'd2, 32'd3);
    in_valid  = 1'b1;
    opcode    = 3'b010;
    operand_a = 32'd100;
    operand_b = 32'd100;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({obs, in_ready} !== {6'b100000, 32'd5, 1'b0}) begin
        $display("FAIL backpressure_hold_%0d: got %h expected %h", i, {obs, in_ready}, {6'b100000, 32'd5, 1'b0});
        n_fail++;
      end
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL backpressure_drain: got %b expected 0", out_valid);
      n_fail++;
    end
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      operand_a = i;
      operand_b = i;
      @(posedge clock);
      @(negedge clock);
      exp_v = 2 * i;
      n_checks++;
      if (obs !== {6'b100000, exp_v}) begin
        $display("FAIL b2b_%0d: got %h expected %h", i, obs, {6'b100000, exp_v});
        n_fail++;
      end
    end
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_end_valid: got %b expected 0", out_valid);
      n_fail++;
    end
  endtask

  task automatic test_mul;
`ifdef ALU_SEQ_MUL_EN
    int cycles;
    int busy_low;
    in_valid  = 1'b1;
    opcode    = 3'b111;
    operand_a = 32'd12345;
    operand_b = 32'd678;
    @(posedge clock);
    @(negedge clock);
    in_valid  = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    cycles    = 1;
    busy_low  = 0;
    while (!out_valid && cycles < 40) begin
      if (!busy) busy_low++;
      @(negedge clock);
      cycles++;
    end
    n_checks++;
    if (cycles != 33) begin
      $display("FAIL mul_latency: got %0d expected 33", cycles);
      n_fail++;
    end
    n_checks++;
    if (busy_low != 0) begin
      $display("FAIL mul_busy: got %0d idle cycles expected 0", busy_low);
      n_fail++;
    end
    n_checks++;
    if (obs !== {6'b100000, 32'd8369910}) begin
      $display("FAIL mul_result: got %h expected %h", obs, {6'b100000, 32'd8369910});
      n_fail++;
    end
    @(negedge clock);
`else
    send(3'b111, 32'd12345, 32'd678);
    n_checks++;
    if (obs !== {6'b100001, 32'd0}) begin
      $display("FAIL mul_illegal: got %h expected %h", obs, {6'b100001, 32'd0});
      n_fail++;
    end
    @(negedge clock);
`endif
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    out_ready = 1'b0;
    send(3'b111, 32'd12345, 32'd678);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({obs, busy, in_ready} !== 40'd0) begin
      $display("FAIL reset_mid_mul: got %h expected %h", {obs, busy, in_ready}, 40'd0);
      n_fail++;
    end
    repeat (2) @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    n_checks++;
    if ({seen[7:0], in_ready} !== {8'd0, 1'b1}) begin
      $display("FAIL post_reset_quiet: got valid_cycles=%0d in_ready=%b expected 0 and 1", seen, in_ready);
      n_fail++;
    end
    send(3'b010, 32'd1, 32'd1);
    n_checks++;
    if (obs !== {6'b100000, 32'd2}) begin
      $display("FAIL post_reset_add: got %h expected %h", obs, {6'b100000, 32'd2});
      n_fail++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 3'b000;
    operand_a = 32'd0;
    operand_b = 32'd0;
    test_reset();
    test_add();
    test_logic();
    test_sub_slt();
    test_shift_zero();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
